// File: rtl/clock_divider_bank.sv
// Bank of independent programmable 50%-duty clock dividers with glitch-free stop.
// Optional macro CLKDIV_RISE_TICK_EN adds a registered one-cycle tick on each clk_out rise.
module clock_divider_bank #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
) (
  input  logic                         clk_in,
  input  logic                         nrst,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS*WIDTH-1:0]    scale,
  output logic [CHANNELS-1:0]          clk_out,
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS-1:0]          clk_rise
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   act_q, act_d;
    logic               out_q, out_d;
    logic               toggle;
    logic [WIDTH-1:0]   sc;

    assign sc     = scale[i*WIDTH +: WIDTH];
    assign toggle = (cnt_q == act_q);

    always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        act_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        act_q   <= act_d;
        out_q   <= out_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      out_d   = out_q;
      case (state_q)
        IDLE: begin
          out_d = 1'b0;
          cnt_d = '0;
          act_d = sc;
          if (en[i]) state_d = RUN;
        end
        RUN, DRAIN: begin
          if (toggle) begin
            cnt_d = '0;
            out_d = ~out_q;
            // Shadow scale only moves at the end of a period (falling toggle).
            if (out_q) act_d = sc;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
          if (!en[i]) begin
            // Low phase (or the edge that ends the high phase) stops at once;
            // otherwise finish the high phase in DRAIN.
            if (!out_q || toggle) begin
              state_d = IDLE;
              cnt_d   = '0;
              out_d   = 1'b0;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
        end
      endcase
    end

    assign clk_out[i] = out_q;
    assign busy[i]    = (state_q != IDLE);

`ifdef CLKDIV_RISE_TICK_EN
    logic rise_q;
    always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) rise_q <= 1'b0;
      else       rise_q <= out_d & ~out_q;
    end
    assign clk_rise[i] = rise_q;
`else
    assign clk_rise[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank (2 channels, 8-bit scale).
module tb_clock_divider_bank;

`ifdef CLKDIV_RISE_TICK_EN
  localparam bit RISE_ON = 1'b1;
`else
  localparam bit RISE_ON = 1'b0;
`endif

  logic        clk_in;
  logic        nrst;
  logic [1:0]  en;
  logic [15:0] scale;
  logic [1:0]  clk_out;
  logic [1:0]  busy;
  logic [1:0]  clk_rise;

  int n_checks = 0;
  int n_pass   = 0;

  clock_divider_bank #(.CHANNELS(2), .WIDTH(8)) dut (
    .clk_in   (clk_in),
    .nrst     (nrst),
    .en       (en),
    .scale    (scale),
    .clk_out  (clk_out),
    .busy     (busy),
    .clk_rise (clk_rise)
  );

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    en   = 2'b00;
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst  = 1'b0;
    en    = 2'b11;
    scale = {8'd1, 8'd0};
    for (int j = 0; j < 5; j++) begin
      tick();
      n_checks++;
      if (clk_out !== 2'b00) $display("FAIL reset clk_out j=%0d: got %b expected 00", j, clk_out);
      else n_pass++;
      n_checks++;
      if (busy !== 2'b00) $display("FAIL reset busy j=%0d: got %b expected 00", j, busy);
      else n_pass++;
      n_checks++;
      if (clk_rise !== 2'b00) $display("FAIL reset clk_rise j=%0d: got %b expected 00", j, clk_rise);
      else n_pass++;
    end
    en = 2'b00;
  endtask

  // ch0 S=0 (period 2), ch1 S=3 (period 8), both enabled at edge k (j=0)
  task automatic test_two_channels();
    logic [1:0] exp_q[$];
    logic [1:0] e, prev, r;
    do_reset();
    scale = {8'd3, 8'd0};
    en    = 2'b11;
    for (int j = 0; j <= 16; j++) exp_q.push_back({((j / 4) % 2) == 1, (j % 2) == 1});
    prev = 2'b00;
    for (int j = 0; j <= 16; j++) begin
      tick();
      e = exp_q.pop_front();
      r = RISE_ON ? (e & ~prev) : 2'b00;
      n_checks++;
      if (clk_out !== e) $display("FAIL two_ch clk_out j=%0d: got %b expected %b", j, clk_out, e);
      else n_pass++;
      n_checks++;
      if (busy !== 2'b11) $display("FAIL two_ch busy j=%0d: got %b expected 11", j, busy);
      else n_pass++;
      n_checks++;
      if (clk_rise !== r) $display("FAIL two_ch clk_rise j=%0d: got %b expected %b", j, clk_rise, r);
      else n_pass++;
      prev = e;
    end
  endtask

  // ch0 S=2, scale rewritten to 5 in the high phase: 3/3 period, then 6/6
  task automatic test_scale_update();
    logic [1:0] e, r;
    do_reset();
    scale = {8'd7, 8'd2};
    en    = 2'b01;
    for (int j = 0; j <= 19; j++) begin
      tick();
      e = {1'b0, (j >= 3 && j <= 5) || (j >= 12 && j <= 17)};
      r = {1'b0, RISE_ON && (j == 3 || j == 12)};
      n_checks++;
      if (clk_out !== e) $display("FAIL scale_upd clk_out j=%0d: got %b expected %b", j, clk_out, e);
      else n_pass++;
      n_checks++;
      if (clk_rise !== r) $display("FAIL scale_upd clk_rise j=%0d: got %b expected %b", j, clk_rise, r);
      else n_pass++;
      n_checks++;
      if (busy !== 2'b01) $display("FAIL scale_upd busy j=%0d: got %b expected 01", j, busy);
      else n_pass++;
      if (j == 4) scale = {8'd7, 8'd5};
    end
  endtask

  // ch0 S=4, en dropped one cycle after the rise: full 5-cycle high, then IDLE
  task automatic test_drain();
    logic [1:0] e, b;
    do_reset();
    scale = {8'd0, 8'd4};
    en    = 2'b01;
    for (int j = 0; j <= 14; j++) begin
      tick();
      e = {1'b0, j >= 5 && j <= 9};
      b = {1'b0, j <= 9};
      n_checks++;
      if (clk_out !== e) $display("FAIL drain clk_out j=%0d: got %b expected %b", j, clk_out, e);
      else n_pass++;
      n_checks++;
      if (busy !== b) $display("FAIL drain busy j=%0d: got %b expected %b", j, busy, b);
      else n_pass++;
      if (j == 6) en = 2'b00;
    end
  endtask

  // ch0 S=4, en dropped in the low phase; re-raised at edge m, rise at m+5
  task automatic test_low_drop();
    logic [1:0] e, b, r;
    do_reset();
    scale = {8'd0, 8'd4};
    en    = 2'b01;
    for (int j = 0; j <= 5; j++) begin
      tick();
      b = {1'b0, j <= 2};
      n_checks++;
      if (busy !== b) $display("FAIL low_drop busy j=%0d: got %b expected %b", j, busy, b);
      else n_pass++;
      n_checks++;
      if (clk_out !== 2'b00) $display("FAIL low_drop clk_out j=%0d: got %b expected 00", j, clk_out);
      else n_pass++;
      if (j == 2) en = 2'b00;
    end
    en = 2'b01;
    for (int j = 0; j <= 7; j++) begin
      tick();
      e = {1'b0, j >= 5};
      r = {1'b0, RISE_ON && j == 5};
      n_checks++;
      if (busy !== 2'b01) $display("FAIL relaunch busy j=%0d: got %b expected 01", j, busy);
      else n_pass++;
      n_checks++;
      if (clk_out !== e) $display("FAIL relaunch clk_out j=%0d: got %b expected %b", j, clk_out, e);
      else n_pass++;
      n_checks++;
      if (clk_rise !== r) $display("FAIL relaunch clk_rise j=%0d: got %b expected %b", j, clk_rise, r);
      else n_pass++;
    end
  endtask

  // ch0 S=1: tick every 4 cycles on each rise; then async reset mid-high
  task automatic test_rise_tick();
    logic [1:0] e, r;
    do_reset();
    scale = {8'd0, 8'd1};
    en    = 2'b01;
    for (int j = 0; j <= 10; j++) begin
      tick();
      e = {1'b0, j >= 2 && ((j / 2) % 2) == 1};
      r = {1'b0, RISE_ON && j >= 2 && (j % 4) == 2};
      n_checks++;
      if (clk_out !== e) $display("FAIL rise_tick clk_out j=%0d: got %b expected %b", j, clk_out, e);
      else n_pass++;
      n_checks++;
      if (clk_rise !== r) $display("FAIL rise_tick clk_rise j=%0d: got %b expected %b", j, clk_rise, r);
      else n_pass++;
    end
    #2 nrst = 1'b0;
    #1;
    n_checks++;
    if (clk_out !== 2'b00) $display("FAIL async_rst clk_out: got %b expected 00", clk_out);
    else n_pass++;
    n_checks++;
    if (busy !== 2'b00) $display("FAIL async_rst busy: got %b expected 00", busy);
    else n_pass++;
    n_checks++;
    if (clk_rise !== 2'b00) $display("FAIL async_rst clk_rise: got %b expected 00", clk_rise);
    else n_pass++;
    en = 2'b00;
    tick();
    nrst = 1'b1;
  endtask

  initial begin
    nrst  = 1'b0;
    en    = 2'b00;
    scale = '0;
    test_reset();
    test_two_channels();
    test_scale_update();
    test_drain();
    test_low_drop();
    test_rise_tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Multi-channel programmable clock divider; successor to the single-channel divider in the tile top level. Each of `CHANNELS` independent channels produces a 50 %-duty divided clock from `clk_in`, with a per-channel enable, a glitch-free stop, and scale changes applied only at period boundaries. It sits between the tile's input switches or register bank and its output pins.

## Interface
- `CHANNELS`, default 2: number of independent divider channels (≥1).
- `WIDTH`, default 8: scale width per channel (≥1).

- `clk_in` input 1: single clock; all logic on its rising edge.
- `nrst` input 1: reset, asynchronous, active-low.
- `en` input CHANNELS: per-channel run enable; bit i drives channel i.
- `scale` input CHANNELS*WIDTH: channel i scale S at `scale[i*WIDTH +: WIDTH]`. Output period is 2*(S+1) `clk_in` cycles.
- `clk_out` output CHANNELS: divided clocks, registered.
- `busy` output CHANNELS: channel not IDLE.
- `clk_rise` output CHANNELS: one-cycle pulse when `clk_out[i]` rises (see Configuration).

## Operation
- Per-channel state: `cnt[WIDTH-1:0]`, shadow scale `act[WIDTH-1:0]`, `clk_out` flop, FSM {IDLE, RUN, DRAIN}. Channels share nothing.
- Reset (`nrst`=0, asynchronous): state IDLE, `cnt`=0, `act`=0, `clk_out`=0, `busy`=0, `clk_rise`=0.
- IDLE: `clk_out`=0, `cnt`=0, `act` <= `scale` each cycle. If `en`=1, go to RUN with `cnt`=0.
- RUN, count step: if `cnt`==`act`, then `cnt`<=0 and `clk_out` toggles. Otherwise `cnt`<=`cnt`+1.
- RUN, scale update: on a falling toggle (1→0, end of period), `act`<=`scale`. Scale writes mid-period never change the current period.
- RUN, `en`=0 while `clk_out`=0: go to IDLE next edge and cut the low phase short. The output stays low, so there is no glitch.
- RUN, `en`=0 while `clk_out`=1: go to DRAIN.
- DRAIN: count as in RUN. On the falling toggle, go to IDLE with `cnt`=0, so the high phase is always full length. If `en` returns to 1 during DRAIN, go to RUN with no phase disturbance.
- A falling toggle together with `en`=0 in RUN: handled as the low-phase case. `clk_out` goes 0 and the state goes IDLE on that edge.
- S=0: toggles every cycle (divide-by-2). S=2^WIDTH−1: period 2^(WIDTH+1). `cnt` never exceeds `act`, so there is no wrap.
- `busy[i]`=1 in RUN and DRAIN.

## Timing
- `en` first sampled high at edge k: RUN after edge k. `clk_out` rises at edge k+S+1 and falls at k+2S+2, then repeats every 2(S+1) edges.
- A `scale` change is visible in the first full period after the next falling toggle.
- `busy` rises on edge k. It falls on the edge the FSM enters IDLE, which is the same edge that `clk_out` falls in the DRAIN exit.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `CLKDIV_RISE_TICK_EN` defined: `clk_rise[i]` is registered and equals 1 for exactly the one cycle in which `clk_out[i]` has just become 1. It is 0 otherwise and 0 in reset.
- Undefined: the `clk_rise` port still exists but is tied to all-zeros, and no tick flops are synthesised.

## Test plan
- Reset, then hold `nrst`=0 with `en`=all-1: `clk_out`=0, `busy`=0, `clk_rise`=0 throughout.
- Ch0 with S=0, ch1 with S=3, `en`=2'b11 at edge k:
  - ch0 clk_out is 1 on k+1, 0 on k+2, and so on (period 2).
  - ch1 rises at k+4 and falls at k+8 (period 8, duty 4/4).
  - `busy`=2'b11 from k.
- S=2 running, write S=5 mid high phase: current period stays 6 cycles. The next period is 12 cycles (6 high, 6 low), starting at the falling edge.
- S=4, drop `en` 1 cycle after `clk_out` rises: `clk_out` stays high the full 5 cycles, then falls. `busy` falls on the same edge and the channel stays IDLE.
- S=4, drop `en` during the low phase: IDLE and `busy`=0 on the next edge, with no high pulse. Re-raise `en` at edge m: first rise at m+5.
- With `CLKDIV_RISE_TICK_EN`, S=1: `clk_rise` pulses for 1 cycle every 4 cycles, coincident with each `clk_out` 0→1. Without the macro it stays 0. Also assert `nrst` mid-high-phase: all outputs go to 0 immediately (asynchronously).
